mac_postproc: RTL and testbench

Downstream stage of the 4-lane MAC controller: takes each finished 26-bit signed dot-product result, adds a per-neuron bias, requantizes by arithmetic right shift, optionally applies ReLU, and saturates to int8. Four int8 activations are packed into one 32-bit word, little-end lane first. Words leave through a 2-entry valid/ready output buffer toward the activation-memory writer, and the final, partial word of a layer is flagged.

---
 rtl/mnist_pkg.sv | 16 +
 rtl/mac_postproc_if.sv | 33 +++
 rtl/mac_postproc_fifo.sv | 60 ++++++
 rtl/mac_postproc.sv | 159 +++++++++++++++
 tb/tb_mac_postproc.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mnist_pkg.sv
// Shared constants and types for the MNIST accelerator datapath.
// Used by the MAC post-processing stage (mac_postproc) and its output FIFO.
package mnist_pkg;

  localparam int ACC_W    = 26;
  localparam int INT8_MAX = 127;
  localparam int INT8_MIN = -128;
  localparam int LANES    = 4;

  // One packed activation word plus its end-of-layer flag
  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } pp_word_t;

endpackage

// File: rtl/mac_postproc_if.sv
// Bus bundle for mac_postproc: the result stream from the MAC controller
// and the packed-word valid/ready stream toward the activation-memory writer.
// master = environment side (MAC controller + consumer), slave = mac_postproc.
interface mac_postproc_if #(
  parameter int ACC_W   = mnist_pkg::ACC_W,
  parameter int BIAS_W  = 16,
  parameter int SHIFT_W = 5
);

  logic               en;
  logic               in_valid;
  logic [ACC_W-1:0]   in_result;
  logic               in_last;
  logic [BIAS_W-1:0]  bias;
  logic [SHIFT_W-1:0] shift;
  logic               relu_en;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_data;
  logic               out_last;
  logic               err_overflow;

  modport master (
    output en, in_valid, in_result, in_last, bias, shift, relu_en, out_ready,
    input  out_valid, out_data, out_last, err_overflow
  );

  modport slave (
    input  en, in_valid, in_result, in_last, bias, shift, relu_en, out_ready,
    output out_valid, out_data, out_last, err_overflow
  );

endinterface

// File: rtl/mac_postproc_fifo.sv
// Two-entry {data,last} output buffer for mac_postproc.
// A push and a pop in the same cycle are both honoured even when full;
// a push into a full buffer with no pop is discarded and flagged on o_drop.
module mac_postproc_fifo
  import mnist_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     i_push,
  input  pp_word_t i_data,
  input  logic     i_pop,
  output pp_word_t o_data,
  output logic     o_empty,
  output logic     o_drop
);

  pp_word_t   r_mem [2];
  logic       r_rd_ptr;
  logic       r_wr_ptr;
  logic [1:0] r_count;

  logic w_full;
  logic w_pop;
  logic w_wr;

  // Occupancy flags and the accept/drop decision for this cycle's push
  always_comb begin
    w_full  = (r_count == 2'd2);
    o_empty = (r_count == 2'd0);
    w_pop   = i_pop && !o_empty;
    w_wr    = i_push && (!w_full || w_pop);
    o_drop  = i_push && w_full && !w_pop;
    o_data  = o_empty ? '0 : r_mem[r_rd_ptr];
  end

  // Storage, pointers and occupancy; when full with a pop, the write lands in the slot being freed
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mac_postproc.sv
// MAC post-processing stage: bias add, requantizing arithmetic right shift,
// optional ReLU, int8 saturation, 4-lane packing and a 2-entry output buffer.
// Optional feature macro: MAC_POSTPROC_ROUND_EN -- when defined, the shift
// rounds half toward +inf; when undefined it truncates toward -inf and the
// rounding adder does not exist.
module mac_postproc #(
  parameter int ACC_W   = mnist_pkg::ACC_W,
  parameter int BIAS_W  = 16,
  parameter int SHIFT_W = 5
) (
  input logic           clk,
  input logic           rst,
  mac_postproc_if.slave bus
);

  import mnist_pkg::*;

  // One guard bit over the accumulator holds result + bias without overflow
  localparam int SUM_W = ACC_W + 1;
  // Requant arithmetic is wide enough to hold the rounding term for the largest shift
  localparam int MAX_SH = (1 << SHIFT_W);
  localparam int EXT_W  = ((SUM_W > MAX_SH) ? SUM_W : MAX_SH) + 2;

  logic                     r_s1_valid;
  logic signed [SUM_W-1:0]  r_s1_sum;
  logic [SHIFT_W-1:0]       r_s1_shift;
  logic                     r_s1_relu;
  logic                     r_s1_last;

  logic                     r_s2_valid;
  logic [7:0]               r_s2_byte;
  logic                     r_s2_last;

  logic [1:0]               r_cnt;
  logic [23:0]              r_partial;
  logic                     r_err;

  logic signed [EXT_W-1:0]  w_ext;
`ifdef MAC_POSTPROC_ROUND_EN
  logic signed [EXT_W-1:0]  w_rnd;
`endif
  logic signed [EXT_W-1:0]  w_q;
  logic [7:0]               w_byte;
  logic [31:0]              w_word;
  logic                     w_push;
  pp_word_t                 w_push_word;
  pp_word_t                 w_head;
  logic                     w_empty;
  logic                     w_drop;
  logic                     w_pop;

  // Stage 1: sign-extend and add the bias, capturing the per-result controls alongside
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sum   <= '0;
      r_s1_shift <= '0;
      r_s1_relu  <= 1'b0;
      r_s1_last  <= 1'b0;
    end else begin
      r_s1_valid <= bus.en && bus.in_valid;
      if (bus.en && bus.in_valid) begin
        r_s1_sum   <= {bus.in_result[ACC_W-1], bus.in_result}
                    + {{(SUM_W-BIAS_W){bus.bias[BIAS_W-1]}}, bus.bias};
        r_s1_shift <= bus.shift;
        r_s1_relu  <= bus.relu_en;
        r_s1_last  <= bus.in_last;
      end
    end
  end

  // Requantize the stage-1 sum: optional half-up rounding, arithmetic shift, ReLU, int8 clamp
  always_comb begin
    w_ext = {{(EXT_W-SUM_W){r_s1_sum[SUM_W-1]}}, r_s1_sum};
`ifdef MAC_POSTPROC_ROUND_EN
    w_rnd = '0;
    if (r_s1_shift != '0) begin
      w_rnd = {{(EXT_W-1){1'b0}}, 1'b1} << (r_s1_shift - SHIFT_W'(1));
    end
    w_q = (w_ext + w_rnd) >>> r_s1_shift;
`else
    w_q = w_ext >>> r_s1_shift;
`endif
    if (r_s1_relu && w_q[EXT_W-1]) begin
      w_q = '0;
    end
    if (w_q > EXT_W'(INT8_MAX)) begin
      w_byte = 8'h7F;
    end else if (w_q < EXT_W'(INT8_MIN)) begin
      w_byte = 8'h80;
    end else begin
      w_byte = w_q[7:0];
    end
  end

  // Stage 2: register the finished int8 activation
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_byte  <= '0;
      r_s2_last  <= 1'b0;
    end else begin
      r_s2_valid <= r_s1_valid;
      r_s2_byte  <= w_byte;
      r_s2_last  <= r_s1_last;
    end
  end

  // Merge the new byte into its lane; unfilled upper lanes stay zero because the partial is cleared on every flush
  always_comb begin
    w_word           = {8'h00, r_partial} | ({24'h000000, r_s2_byte} << {r_cnt, 3'b000});
    w_push           = r_s2_valid && ((r_cnt == 2'(LANES-1)) || r_s2_last);
    w_push_word.data = w_word;
    w_push_word.last = r_s2_last;
    w_pop            = !w_empty && bus.out_ready;
  end

  // Packer lane counter and partial word; a full word or layer end restarts at lane 0
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= 2'd0;
      r_partial <= '0;
    end else if (r_s2_valid) begin
      if (w_push) begin
        r_cnt     <= 2'd0;
        r_partial <= '0;
      end else begin
        r_cnt     <= r_cnt + 2'd1;
        r_partial <= w_word[23:0];
      end
    end
  end

  mac_postproc_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_word),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_drop  (w_drop)
  );

  // Sticky overflow flag: once a word is lost only reset clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_drop) begin
      r_err <= 1'b1;
    end
  end

  assign bus.out_valid    = !w_empty;
  assign bus.out_data     = w_head.data;
  assign bus.out_last     = w_head.last;
  assign bus.err_overflow = r_err;

endmodule

// File: tb/tb_mac_postproc.sv
// Self-checking bench for mac_postproc: directed checks with fixed expected
// words plus randomized streams compared against an arithmetic reference
// model. Expectations follow MAC_POSTPROC_ROUND_EN as the build defines it.
module tb_mac_postproc;

  import mnist_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int compared   = 0;
  int mismatched = 0;

  logic [32:0] expQ[$];
  logic [32:0] obsQ[$];
  time         obsTime[$];
  logic [7:0]  modelBytes[$];

  mac_postproc_if bus ();

  mac_postproc dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  // Record every word the consumer takes; sampled mid-cycle so the handshake is settled
  always @(negedge clk) begin
    if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      obsQ.push_back({bus.out_data, bus.out_last});
      obsTime.push_back($time);
    end
  end

  // Reference requantizer: plain signed arithmetic on wide integers
  function automatic logic [7:0] refByte(input longint res, input longint b, input int sh, input bit relu);
    longint v;
    v = res + b;
`ifdef MAC_POSTPROC_ROUND_EN
    if (sh > 0) v = v + (longint'(1) << (sh - 1));
`endif
    v = v >>> sh;
    if (relu && v < 0) v = 0;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return v[7:0];
  endfunction

  // Reference packer: collect bytes, emit a word at four bytes or at the layer end
  task automatic modelPush(input logic [7:0] b, input bit last);
    logic [31:0] word;
    modelBytes.push_back(b);
    if (modelBytes.size() == 4 || last) begin
      word = '0;
      for (int i = 0; i < modelBytes.size(); i++) word[i*8 +: 8] = modelBytes[i];
      expQ.push_back({word, last});
      modelBytes.delete();
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one result for exactly one clock edge and update the model if it is accepted
  task automatic applyStimulus(input int res, input int b, input int sh, input bit relu,
                               input bit last, input bit enable);
    bus.en        = enable;
    bus.in_valid  = 1'b1;
    bus.in_result = res[25:0];
    bus.bias      = b[15:0];
    bus.shift     = sh[4:0];
    bus.relu_en   = relu;
    bus.in_last   = last;
    if (enable) modelPush(refByte(res, b, sh, relu), last);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.en       = 1'b1;
  endtask

  task automatic clearQueues();
    expQ.delete();
    obsQ.delete();
    obsTime.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    waitCycles(2);
    compared++;
    if (bus.out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    compared++;
    if (bus.out_data !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_out_data: got %h want 00000000", bus.out_data); end
    compared++;
    if (bus.out_last !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_last: got %b want 0", bus.out_last); end
    compared++;
    if (bus.err_overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_err: got %b want 0", bus.err_overflow); end
    rst = 1'b0;
    waitCycles(1);
    clearQueues();
    modelBytes.delete();
  endtask

  task automatic test_rounding();
    logic [32:0] want;
`ifdef MAC_POSTPROC_ROUND_EN
    want = {32'h0000000D, 1'b0};
`else
    want = {32'h0000000C, 1'b0};
`endif
    applyStimulus(100, 0, 3, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 3, 1'b0, 1'b0, 1'b1);
    waitCycles(5);
    compared++;
    if (obsQ.size() != 1 || obsQ[0] !== want) begin
      mismatched++;
      $display("[TB] FAIL rounding: got %0d words first %h want %h", obsQ.size(), (obsQ.size() > 0) ? obsQ[0] : 33'h0, want);
    end
    clearQueues();
  endtask

  task automatic test_packing();
    for (int i = 1; i <= 4; i++) applyStimulus(i, 0, 0, 1'b0, 1'b0, 1'b1);
    waitCycles(1);
    compared++;
    if (bus.out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL packing_early: got out_valid %b want 0", bus.out_valid); end
    waitCycles(1);
    compared++;
    if (bus.out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL packing_latency: got out_valid %b want 1", bus.out_valid); end
    compared++;
    if ({bus.out_data, bus.out_last} !== {32'h04030201, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL packing_word: got %h/%b want 04030201/0", bus.out_data, bus.out_last);
    end
    waitCycles(3);
    clearQueues();
  endtask

  task automatic test_saturation();
    applyStimulus(-500, 0, 2, 1'b1, 1'b0, 1'b1);
    applyStimulus(-500, 0, 2, 1'b0, 1'b0, 1'b1);
    applyStimulus(-600, 0, 2, 1'b0, 1'b0, 1'b1);
    applyStimulus(1000, 24, 2, 1'b0, 1'b0, 1'b1);
    waitCycles(5);
    compared++;
    if (obsQ.size() != 1 || obsQ[0] !== {32'h7F808300, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL saturation: got %0d words first %h want %h", obsQ.size(), (obsQ.size() > 0) ? obsQ[0] : 33'h0, {32'h7F808300, 1'b0});
    end
    clearQueues();
  endtask

  task automatic test_flush();
    applyStimulus(5, 0, 0, 1'b0, 1'b0, 1'b1);
    applyStimulus(6, 0, 0, 1'b0, 1'b1, 1'b1);
    for (int i = 7; i <= 10; i++) applyStimulus(i, 0, 0, 1'b0, 1'b0, 1'b1);
    waitCycles(5);
    compared++;
    if (obsQ.size() != 2 || obsQ[0] !== {32'h00000605, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL flush_word: got %0d words first %h want %h", obsQ.size(), (obsQ.size() > 0) ? obsQ[0] : 33'h0, {32'h00000605, 1'b1});
    end
    compared++;
    if (obsQ.size() != 2 || obsQ[1] !== {32'h0A090807, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL flush_next_lane0: got %0d words second %h want %h", obsQ.size(), (obsQ.size() > 1) ? obsQ[1] : 33'h0, {32'h0A090807, 1'b0});
    end
    clearQueues();
  endtask

  task automatic test_back_pressure();
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 12; i++) applyStimulus(i, 0, 0, 1'b0, 1'b0, 1'b1);
    waitCycles(4);
    compared++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h04030201) begin
      mismatched++;
      $display("[TB] FAIL bp_head: got %b/%h want 1/04030201", bus.out_valid, bus.out_data);
    end
    compared++;
    if (bus.err_overflow !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_overflow: got %b want 1", bus.err_overflow); end
    bus.out_ready = 1'b1;
    waitCycles(5);
    compared++;
    if (obsQ.size() != 2 || obsQ[0] !== {32'h04030201, 1'b0} || obsQ[1] !== {32'h08070605, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL bp_drain: got %0d words %h %h want 2 words %h %h", obsQ.size(),
               (obsQ.size() > 0) ? obsQ[0] : 33'h0, (obsQ.size() > 1) ? obsQ[1] : 33'h0,
               {32'h04030201, 1'b0}, {32'h08070605, 1'b0});
    end
    compared++;
    if (bus.out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_empty: got out_valid %b want 0", bus.out_valid); end
    clearQueues();
  endtask

  task automatic test_reset_midword();
    applyStimulus(8'h11, 0, 0, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h22, 0, 0, 1'b0, 1'b0, 1'b1);
    waitCycles(3);
    rst = 1'b1;
    waitCycles(1);
    rst = 1'b0;
    modelBytes.delete();
    compared++;
    if (bus.out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_valid: got %b want 0", bus.out_valid); end
    compared++;
    if (bus.err_overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_err: got %b want 0", bus.err_overflow); end
    for (int i = 1; i <= 4; i++) applyStimulus(i, 0, 0, 1'b0, 1'b0, 1'b1);
    waitCycles(5);
    compared++;
    if (obsQ.size() != 1 || obsQ[0] !== {32'h04030201, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL midreset_clean_word: got %0d words first %h want %h", obsQ.size(), (obsQ.size() > 0) ? obsQ[0] : 33'h0, {32'h04030201, 1'b0});
    end
    clearQueues();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(int'($urandom) >>> 6, int'($urandom) >>> 16, $urandom_range(0, 12), 1'($urandom), 1'b1, 1'b1);
    end
    waitCycles(6);
    compared++;
    if (obsQ.size() != expQ.size()) begin
      mismatched++;
      $display("[TB] FAIL b2b_count: got %0d words want %0d", obsQ.size(), expQ.size());
    end
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
      compared++;
      if (obsQ[i] !== expQ[i]) begin mismatched++; $display("[TB] FAIL b2b_word%0d: got %h want %h", i, obsQ[i], expQ[i]); end
    end
    compared++;
    if (obsTime.size() != 8 || (obsTime[7] - obsTime[0]) != 70) begin
      mismatched++;
      $display("[TB] FAIL b2b_throughput: got %0d words spanning %0t want 8 words spanning 70", obsTime.size(),
               (obsTime.size() > 0) ? obsTime[obsTime.size()-1] - obsTime[0] : 0);
    end
    clearQueues();
  endtask

  task automatic test_random();
    int sh;
    for (int n = 0; n < 300; n++) begin
      sh = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 31) : $urandom_range(0, 12);
      applyStimulus(int'($urandom) >>> 6, int'($urandom) >>> 16, sh, 1'($urandom),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) != 0));
      if ($urandom_range(0, 3) == 0) waitCycles($urandom_range(1, 3));
    end
    applyStimulus(3, 0, 0, 1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 100 && obsQ.size() < expQ.size(); c++) @(posedge clk);
    waitCycles(4);
    compared++;
    if (obsQ.size() != expQ.size()) begin
      mismatched++;
      $display("[TB] FAIL random_count: got %0d words want %0d", obsQ.size(), expQ.size());
    end
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
      compared++;
      if (obsQ[i] !== expQ[i]) begin mismatched++; $display("[TB] FAIL random_word%0d: got %h want %h", i, obsQ[i], expQ[i]); end
    end
    compared++;
    if (bus.err_overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL random_no_overflow: got %b want 0", bus.err_overflow); end
    clearQueues();
  endtask

  // Run every scenario in order, then report
  initial begin
    bus.en        = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_result = '0;
    bus.in_last   = 1'b0;
    bus.bias      = '0;
    bus.shift     = '0;
    bus.relu_en   = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_rounding();
    test_packing();
    test_saturation();
    test_flush();
    test_back_pressure();
    test_reset_midword();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
